// File: rtl/addsub_arbiter.sv
// addsub_arbiter: two requesters share one 4-bit add/sub datapath (IDLE/EXEC/RESP).
// Define ADDSUB_ARB_RR_EN for round-robin arbitration; default is fixed priority (r0 first).
module addsub_arbiter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       r0_valid,
    output logic       r0_ready,
    input  logic [3:0] r0_a,
    input  logic [3:0] r0_b,
    input  logic       r0_sub,
    input  logic       r1_valid,
    output logic       r1_ready,
    input  logic [3:0] r1_a,
    input  logic [3:0] r1_b,
    input  logic       r1_sub,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic [3:0] rsp_mag,
    output logic       rsp_neg,
    output logic       rsp_cout,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t     state, state_nxt;
    logic       grant, last_grant, accept;
    logic [3:0] op_a, op_b;
    logic       op_sub, op_id;
    logic [4:0] sum;
    logic [3:0] s, mag;
    logic       cout, neg;

    // With no request pending the grant parks on the last winner; it is unused then.
    always_comb begin
`ifdef ADDSUB_ARB_RR_EN
        if (r0_valid && r1_valid) grant = ~last_grant;
        else if (r1_valid)        grant = 1'b1;
        else if (r0_valid)        grant = 1'b0;
        else                      grant = last_grant;
`else
        if (r0_valid)             grant = 1'b0;
        else if (r1_valid)        grant = 1'b1;
        else                      grant = last_grant;
`endif
    end

    assign r0_ready = (state == IDLE) && !grant && r0_valid;
    assign r1_ready = (state == IDLE) &&  grant && r1_valid;
    assign accept   = r0_ready || r1_ready;
    assign busy     = (state != IDLE);

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Subtraction as A + ~B + 1; a missing carry means the result went negative.
    always_comb begin
        sum  = {1'b0, op_a} + {1'b0, op_b ^ {4{op_sub}}} + {4'b0, op_sub};
        s    = sum[3:0];
        cout = sum[4];
        neg  = op_sub & ~cout;
        mag  = neg ? (~s + 4'd1) : s;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            op_a       <= '0;
            op_b       <= '0;
            op_sub     <= 1'b0;
            op_id      <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_mag    <= '0;
            rsp_neg    <= 1'b0;
            rsp_cout   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && accept) begin
                op_a       <= grant ? r1_a : r0_a;
                op_b       <= grant ? r1_b : r0_b;
                op_sub     <= grant ? r1_sub : r0_sub;
                op_id      <= grant;
                last_grant <= grant;
            end
            if (state == EXEC) begin
                rsp_valid <= 1'b1;
                rsp_id    <= op_id;
                rsp_mag   <= mag;
                rsp_neg   <= neg;
                rsp_cout  <= cout;
            end
            if (state == RESP && rsp_ready) rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_addsub_arbiter.sv
// tb_addsub_arbiter: scoreboard bench for the shared add/sub arbiter.
// Define ADDSUB_ARB_RR_EN here as for the RTL to expect round-robin grants.
module tb_addsub_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       r0_valid = 1'b0, r1_valid = 1'b0;
    logic       r0_ready, r1_ready;
    logic [3:0] r0_a = '0, r0_b = '0, r1_a = '0, r1_b = '0;
    logic       r0_sub = 1'b0, r1_sub = 1'b0;
    logic       rsp_valid, rsp_ready = 1'b1;
    logic       rsp_id, rsp_neg, rsp_cout, busy;
    logic [3:0] rsp_mag;

    typedef struct packed {
        logic       id;
        logic [3:0] mag;
        logic       neg;
        logic       cout;
    } exp_t;

    exp_t sb[$];
    int   grants[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   rsp_seen = 0;

    always #5 clk = ~clk;

    addsub_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .r0_valid(r0_valid), .r0_ready(r0_ready),
        .r0_a(r0_a), .r0_b(r0_b), .r0_sub(r0_sub),
        .r1_valid(r1_valid), .r1_ready(r1_ready),
        .r1_a(r1_a), .r1_b(r1_b), .r1_sub(r1_sub),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_mag(rsp_mag),
        .rsp_neg(rsp_neg), .rsp_cout(rsp_cout),
        .busy(busy)
    );

    function automatic exp_t model(input logic id, input logic [3:0] a,
                                   input logic [3:0] b, input logic sub);
        exp_t e;
        int   d;
        e.id = id;
        if (sub) begin
            d      = int'(a) - int'(b);
            e.neg  = (d < 0);
            e.cout = (d >= 0);
            e.mag  = 4'(d < 0 ? -d : d);
        end else begin
            d      = int'(a) + int'(b);
            e.neg  = 1'b0;
            e.cout = (d > 15);
            e.mag  = 4'(d % 16);
        end
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (r0_valid && r0_ready) begin
                sb.push_back(model(1'b0, r0_a, r0_b, r0_sub));
                grants.push_back(0);
            end
            if (r1_valid && r1_ready) begin
                sb.push_back(model(1'b1, r1_a, r1_b, r1_sub));
                grants.push_back(1);
            end
            if (rsp_valid && rsp_ready) begin
                rsp_seen++;
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_rsp got id=%0d mag=%0d neg=%0d cout=%0d, none expected",
                             rsp_id, rsp_mag, rsp_neg, rsp_cout);
                end else begin
                    e = sb.pop_front();
                    if ({rsp_id, rsp_mag, rsp_neg, rsp_cout} !== e) begin
                        miscompares++;
                        $display("FAIL rsp got id=%0d mag=%0d neg=%0d cout=%0d exp id=%0d mag=%0d neg=%0d cout=%0d",
                                 rsp_id, rsp_mag, rsp_neg, rsp_cout, e.id, e.mag, e.neg, e.cout);
                    end
                end
            end
        end
    end

    task automatic issue(input logic id, input logic [3:0] a,
                         input logic [3:0] b, input logic sub);
        bit got = 1'b0;
        if (id) begin
            r1_a = a; r1_b = b; r1_sub = sub; r1_valid = 1'b1;
        end else begin
            r0_a = a; r0_b = b; r0_sub = sub; r0_valid = 1'b1;
        end
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = id ? r1_ready : r0_ready;
        end
        @(posedge clk); #1;
        r0_valid = 1'b0;
        r1_valid = 1'b0;
        vectors++;
        if (!got) begin
            miscompares++;
            $display("FAIL accept_timeout id=%0d got no ready, expected ready", id);
        end
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int i = 0; i < 30 && !done; i++) begin
            @(posedge clk); #1;
            done = !busy && (sb.size() == 0);
        end
        vectors++;
        if (!done) begin
            miscompares++;
            $display("FAIL idle_timeout busy=%0d pending=%0d, expected 0/0", busy, sb.size());
        end
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        #12;
        vectors++;
        if ({rsp_valid, rsp_mag, rsp_neg, rsp_cout, rsp_id, busy, r0_ready, r1_ready} !== 11'b0) begin
            miscompares++;
            $display("FAIL reset_values got v=%0d mag=%0d neg=%0d cout=%0d id=%0d busy=%0d, expected all 0",
                     rsp_valid, rsp_mag, rsp_neg, rsp_cout, rsp_id, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        vectors++;
        if ({busy, rsp_valid, r0_ready, r1_ready} !== 4'b0) begin
            miscompares++;
            $display("FAIL idle_no_req got busy=%0d v=%0d rdy=%0d%0d, expected 0",
                     busy, rsp_valid, r0_ready, r1_ready);
        end
    endtask

    task automatic test_basic();
        rsp_ready = 1'b1;
        r0_a = 4'd5; r0_b = 4'd3; r0_sub = 1'b0; r0_valid = 1'b1;
        @(negedge clk);
        vectors++;
        if ({r0_ready, r1_ready} !== 2'b10) begin
            miscompares++;
            $display("FAIL accept_ready got r0=%0d r1=%0d, expected 1/0", r0_ready, r1_ready);
        end
        @(posedge clk); #1;
        r0_valid = 1'b0;
        vectors++;
        if ({busy, rsp_valid} !== 2'b10) begin
            miscompares++;
            $display("FAIL exec_state got busy=%0d v=%0d, expected 1/0", busy, rsp_valid);
        end
        @(posedge clk); #1;
        vectors++;
        if ({rsp_valid, rsp_id, rsp_mag, rsp_neg, rsp_cout} !== {1'b1, 1'b0, 4'd8, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL latency got v=%0d id=%0d mag=%0d neg=%0d cout=%0d, expected 1/0/8/0/0",
                     rsp_valid, rsp_id, rsp_mag, rsp_neg, rsp_cout);
        end
        wait_idle();
    endtask

    task automatic test_sub();
        issue(1'b1, 4'd3, 4'd7, 1'b1);
        wait_idle();
        issue(1'b1, 4'd0, 4'd15, 1'b1);
        wait_idle();
        issue(1'b1, 4'd15, 4'd0, 1'b1);
        wait_idle();
    endtask

    task automatic test_add_overflow();
        issue(1'b0, 4'd12, 4'd9, 1'b0);
        wait_idle();
        issue(1'b0, 4'd9, 4'd9, 1'b1);
        wait_idle();
        issue(1'b0, 4'd15, 4'd15, 1'b0);
        wait_idle();
    endtask

    task automatic test_random();
        for (int i = 0; i < 10; i++) begin
            issue(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            wait_idle();
        end
    endtask

    task automatic test_stall();
        rsp_ready = 1'b0;
        issue(1'b1, 4'd3, 4'd7, 1'b1);
        r0_a = 4'd1; r0_b = 4'd1; r0_sub = 1'b0; r0_valid = 1'b1;
        r1_a = 4'd2; r1_b = 4'd2; r1_sub = 1'b0; r1_valid = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vectors++;
            if ({rsp_valid, rsp_id, rsp_mag, rsp_neg, rsp_cout, busy, r0_ready, r1_ready}
                !== {1'b1, 1'b1, 4'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0}) begin
                miscompares++;
                $display("FAIL stall_hold cyc=%0d got v=%0d id=%0d mag=%0d neg=%0d cout=%0d busy=%0d rdy=%0d%0d",
                         i, rsp_valid, rsp_id, rsp_mag, rsp_neg, rsp_cout, busy, r0_ready, r1_ready);
            end
        end
        @(posedge clk); #1;
        r0_valid = 1'b0;
        r1_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if ({busy, rsp_valid, rsp_mag, rsp_neg} !== {1'b0, 1'b0, 4'd4, 1'b1}) begin
            miscompares++;
            $display("FAIL stall_release got busy=%0d v=%0d mag=%0d neg=%0d, expected 0/0/4/1",
                     busy, rsp_valid, rsp_mag, rsp_neg);
        end
        wait_idle();
    endtask

    task automatic test_reset_mid();
        int seen;
        rsp_ready = 1'b1;
        issue(1'b0, 4'd6, 4'd2, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({rsp_valid, busy, rsp_mag, rsp_id} !== 7'b0) begin
            miscompares++;
            $display("FAIL reset_mid got v=%0d busy=%0d mag=%0d id=%0d, expected 0",
                     rsp_valid, busy, rsp_mag, rsp_id);
        end
        sb.delete();
        seen = rsp_seen;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        vectors++;
        if (rsp_seen != seen || rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_discard got %0d responses v=%0d, expected 0 and 0",
                     rsp_seen - seen, rsp_valid);
        end
    endtask

    task automatic test_arbitration();
        int exp_g[4];
`ifdef ADDSUB_ARB_RR_EN
        exp_g = '{0, 1, 0, 1};
`else
        exp_g = '{0, 0, 0, 0};
`endif
        apply_reset();
        grants.delete();
        rsp_ready = 1'b1;
        r0_a = 4'd2; r0_b = 4'd3; r0_sub = 1'b0; r0_valid = 1'b1;
        r1_a = 4'd7; r1_b = 4'd9; r1_sub = 1'b1; r1_valid = 1'b1;
        for (int i = 0; i < 40 && grants.size() < 4; i++) @(negedge clk);
        @(posedge clk); #1;
        r0_valid = 1'b0;
        r1_valid = 1'b0;
        wait_idle();
        vectors++;
        if (grants.size() < 4) begin
            miscompares++;
            $display("FAIL grant_count got %0d grants, expected 4", grants.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                vectors++;
                if (grants[i] != exp_g[i]) begin
                    miscompares++;
                    $display("FAIL grant_order idx=%0d got %0d expected %0d", i, grants[i], exp_g[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sub();
        test_add_overflow();
        test_random();
        test_stall();
        test_reset_mid();
        test_arbitration();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/addsub_arbiter.md
ADDSUB_ARBITER -- requirements
Module: addsub_arbiter

Interface
REQ-001 The block SHALL use one clock and an asynchronous active-low reset, with ports clk and rst_n.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 r0_valid / r1_valid  input  1  requester 0/1 has an operation pending.
REQ-005 r0_ready / r1_ready  output  1  requester 0/1 operation is accepted this cycle.
REQ-006 r0_a, r0_b / r1_a, r1_b  input  4  unsigned operands.
REQ-007 r0_sub / r1_sub  input  1  operation select: 0 = A+B, 1 = A-B.
REQ-008 rsp_valid  output  1  result held on rsp_* is valid.
REQ-009 rsp_ready  input  1  consumer accepts the result.
REQ-010 rsp_id  output  1  index of the requester that owns the result.
REQ-011 rsp_mag  output  4  result magnitude.
REQ-012 rsp_neg  output  1  sign of the result: 1 = negative.
REQ-013 rsp_cout  output  1  raw carry out of the 4-bit adder.
REQ-014 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-015 The block SHALL share a single 4-bit add/sub datapath between the two requesters, using an FSM with states IDLE, EXEC and RESP.
REQ-016 IDLE: rX_ready SHALL be driven combinationally as (state==IDLE && grant==X && rX_valid); at most one ready SHALL be high in any cycle.
REQ-017 When rX_valid && rX_ready at a clock edge, the block SHALL latch A, B, sub and id, record the winner as last_grant, and move to EXEC.
REQ-018 In IDLE with no valid request, the FSM SHALL remain in IDLE and both readies SHALL be 0.
REQ-019 EXEC: the block SHALL compute S = A + (B XOR {4{sub}}) + sub, with cout the carry out of bit 3.
REQ-020 EXEC: the block SHALL register rsp_cout = cout.
REQ-021 EXEC, sign: when sub=0, rsp_neg SHALL be 0; when sub=1, rsp_neg SHALL be ~cout.
REQ-022 EXEC, magnitude: rsp_mag SHALL be (~S+1) mod 16 when rsp_neg=1, otherwise S.
REQ-023 EXEC SHALL then set rsp_valid=1 and move to RESP.
REQ-024 Addition overflow SHALL be reported only through rsp_cout, with rsp_mag = sum mod 16.
REQ-025 For subtraction, the full range 0-15 ... 15-0 SHALL be exact; for example, 0-15 gives mag=15 and neg=1.
REQ-026 RESP: rsp_* SHALL hold stable until rsp_valid && rsp_ready; on that edge rsp_valid SHALL go to 0 and the FSM SHALL return to IDLE.
REQ-027 Latency: the result SHALL be visible on the second rising edge after acceptance, and minimum throughput SHALL be one operation per 3 cycles.
REQ-028 New requests arriving while busy SHALL wait with readies low; requesters SHALL hold valid and operands until ready.
REQ-029 rsp_mag, rsp_neg, rsp_cout and rsp_id SHALL retain their last values after the handshake until the next EXEC.

Reset
REQ-030 On rst_n=0, the block SHALL force state=IDLE, rsp_valid=0, rsp_mag=0, rsp_neg=0, rsp_cout=0, rsp_id=0, busy=0 and last_grant=1, asynchronously.
REQ-031 Reset asserted in EXEC or RESP SHALL discard the in-flight operation with no response issued.
REQ-032 After reset release, the first grant SHALL go to requester 0 when both requesters are valid.

Configuration
REQ-033 With ADDSUB_ARB_RR_EN defined, arbitration SHALL be round-robin: when both are valid, grant goes to the requester that is not last_grant; a single valid requester is always granted.
REQ-034 With ADDSUB_ARB_RR_EN undefined, arbitration SHALL be fixed priority: r0 wins whenever r0_valid=1, and last_grant is still maintained but unused.

Verification
REQ-035 Reset, then r0: A=5, B=3, sub=0, with rsp_ready=1 -> r0_ready high in the accept cycle; 2 edges later rsp_valid=1, id=0, mag=8, neg=0, cout=0.
REQ-036 r1: A=3, B=7, sub=1 -> mag=4, neg=1, cout=0, id=1; A=0, B=15, sub=1 -> mag=15, neg=1.
REQ-037 r0: A=12, B=9, sub=0 -> mag=5, cout=1, neg=0; r0: A=9, B=9, sub=1 -> mag=0, neg=0, cout=1.
REQ-038 Both requesters valid continuously, RR_EN defined -> grants alternate 0,1,0,1; RR_EN undefined -> all grants go to 0 while r0_valid=1.
REQ-039 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_* stable, busy=1, and both readies 0 throughout; release -> IDLE next cycle.
REQ-040 Assert rst_n=0 mid-EXEC -> rsp_valid=0 and busy=0 immediately, and no response is produced after release.
